// File: rtl/zmem_stream.sv
// Whitened-data (Z) buffer for FastICA: random-access write port plus a
// two-channel, sample-ordered streaming read engine with valid/ready flow control.
module zmem_stream #(
   parameter int DATA_WIDTH = 16,
   parameter int M          = 1024,
   parameter int N          = 7,
   parameter int LATENCY    = 1,
   parameter int SAMP_W     = $clog2(M),
   parameter int CH_W       = (N > 1) ? $clog2(N) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [SAMP_W-1:0]     wr_samp,
   input  logic [CH_W-1:0]       wr_ch,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  start,
   input  logic [CH_W-1:0]       ch_a,
   input  logic [CH_W-1:0]       ch_b,
   input  logic                  dout_ready,
   output logic [DATA_WIDTH-1:0] dout_a,
   output logic [DATA_WIDTH-1:0] dout_b,
   output logic [SAMP_W-1:0]     dout_samp,
   output logic                  dout_valid,
   output logic                  dout_last,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int DEPTH  = M * N;
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [SAMP_W-1:0] LAST_SAMP = SAMP_W'(M - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t state, state_nx;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   logic [SAMP_W-1:0]     issue_cnt, issue_cnt_nx;
   logic [CH_W-1:0]       sel_a, sel_b;
   logic                  done_nx, err_nx;
   logic                  start_ok, ch_ok, wr_range_ok, wr_ok, issue, final_hs;
   logic                  stage_full;

   // Stage 0 holds the issued address pair; stages 1..LATENCY carry read data.
   logic [LATENCY:0]      vld, adv;
   logic [SAMP_W-1:0]     samp_q [0:LATENCY];
   logic [ADDR_W-1:0]     addr_a, addr_b;
   logic [DATA_WIDTH-1:0] data_a [1:LATENCY];
   logic [DATA_WIDTH-1:0] data_b [1:LATENCY];
   logic [ADDR_W-1:0]     wr_addr;

   assign ch_ok       = (int'(ch_a) < N) && (int'(ch_b) < N);
   assign wr_range_ok = (int'(wr_samp) < M) && (int'(wr_ch) < N);
   assign busy        = (state != IDLE);
   assign wr_ok       = wr_en && !busy && wr_range_ok;
   assign start_ok    = start && !busy && ch_ok;
   assign wr_addr     = ADDR_W'(wr_samp) * ADDR_W'(N) + ADDR_W'(wr_ch);

   assign dout_valid  = vld[LATENCY];
   assign dout_samp   = samp_q[LATENCY];
   assign dout_a      = data_a[LATENCY];
   assign dout_b      = data_b[LATENCY];
   assign dout_last   = vld[LATENCY] && (samp_q[LATENCY] == LAST_SAMP);
   assign final_hs    = dout_last && dout_ready;

   // A stage may load when some stage at or below it has a hole, or the output drains.
   always_comb begin
      stage_full = 1'b1;
      adv        = '0;
      for (int k = LATENCY; k >= 0; k--) begin
         stage_full = stage_full & vld[k];
         adv[k]     = dout_ready | ~stage_full;
      end
   end

   assign issue = (state == RUN) && adv[0];

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld    <= '0;
         addr_a <= '0;
         addr_b <= '0;
         for (int k = 0; k <= LATENCY; k++) begin
            samp_q[k] <= '0;
         end
         for (int k = 1; k <= LATENCY; k++) begin
            data_a[k] <= '0;
            data_b[k] <= '0;
         end
      end else begin
         if (adv[0]) begin
            vld[0] <= issue;
            if (issue) begin
               samp_q[0] <= issue_cnt;
               addr_a    <= ADDR_W'(issue_cnt) * ADDR_W'(N) + ADDR_W'(sel_a);
               addr_b    <= ADDR_W'(issue_cnt) * ADDR_W'(N) + ADDR_W'(sel_b);
            end
         end
         if (adv[1]) begin
            vld[1]    <= vld[0];
            samp_q[1] <= samp_q[0];
            data_a[1] <= mem[addr_a];
            data_b[1] <= mem[addr_b];
         end
         for (int k = 2; k <= LATENCY; k++) begin
            if (adv[k]) begin
               vld[k]    <= vld[k-1];
               samp_q[k] <= samp_q[k-1];
               data_a[k] <= data_a[k-1];
               data_b[k] <= data_b[k-1];
            end
         end
      end
   end

   always_comb begin
      state_nx     = state;
      issue_cnt_nx = issue_cnt;
      done_nx      = 1'b0;
      err_nx       = (start && (busy || !ch_ok)) || (wr_en && (busy || !wr_range_ok));
      case (state)
         IDLE: begin
            if (start_ok) begin
               state_nx     = RUN;
               issue_cnt_nx = '0;
            end
         end
         RUN: begin
            if (issue) begin
               issue_cnt_nx = issue_cnt + 1'b1;
               if (issue_cnt == LAST_SAMP) begin
                  state_nx = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (final_hs) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         issue_cnt <= '0;
         sel_a     <= '0;
         sel_b     <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nx;
         issue_cnt <= issue_cnt_nx;
         done      <= done_nx;
         err       <= err_nx;
         if (start_ok) begin
            sel_a <= ch_a;
            sel_b <= ch_b;
         end
      end
   end

endmodule

// File: doc/zmem_stream.md
Name: zmem_stream

Overview:
- Whitened-data (Z) buffer for FastICA: stores an M-sample by N-channel matrix of signed fixed-point words.
- Loaded one word per cycle through a random-access write port.
- Replays any two channels as a sample-ordered stream for the fixed-point update and decorrelation stages.
- Streaming read engine: valid/ready backpressure, programmable read pipeline latency, last/done framing, error flags.

Parameters:
- DATA_WIDTH, 16, width of one Z sample word.
- M, 1024, samples per channel; must be 2 or more.
- N, 7, channel count; must be 1 or more.
- LATENCY, 1, read pipeline stages from address issue to dout register; legal range 1..4.
- SAMP_W, $clog2(M), sample index width; derived, do not override.
- CH_W, max(1,$clog2(N)), channel index width; derived, do not override.

Ports:
- clk  in  1  clock, all logic on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  write strobe
- wr_samp  in  SAMP_W  write sample index
- wr_ch  in  CH_W  write channel index
- wr_data  in  DATA_WIDTH  write data
- start  in  1  single-cycle request to begin a sweep
- ch_a  in  CH_W  channel for stream A; sampled when start is accepted
- ch_b  in  CH_W  channel for stream B; sampled when start is accepted
- dout_ready  in  1  consumer ready
- dout_a  out  DATA_WIDTH  Z[samp][ch_a]
- dout_b  out  DATA_WIDTH  Z[samp][ch_b]
- dout_samp  out  SAMP_W  sample index of the current beat
- dout_valid  out  1  beat valid
- dout_last  out  1  beat is sample M-1
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse after the last beat is handshaked
- err  out  1  one-cycle pulse on a rejected request

Behaviour:
- Reset: clk and rst_n are already decided as above (asynchronous, active-low). All outputs reset to 0; sweep counters and pipeline valid bits reset to 0.
- Storage array has no reset; contents are retained across rst_n so it maps to block RAM. Data is flat-addressed as samp*N + ch.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN: on start with busy=0, ch_a<N and ch_b<N.
  - The channels are latched at acceptance.
  - busy goes to 1 in the next cycle.
  - The issue counter resets to 0.
- start while busy=1: ignored, and err pulses.
- start with ch_a>=N or ch_b>=N: rejected, err pulses, state stays IDLE.
- RUN:
  - Each cycle the pipeline can advance, issue one address pair (issue counter, ch_a/ch_b) and increment the counter.
  - After issuing sample M-1, go to DRAIN.
- DRAIN: wait for the final beat handshake (dout_valid & dout_ready & dout_last), then go to IDLE.
  - busy=0 and done=1 in the cycle after that handshake.
  - A new start is accepted in that same cycle.
- Latency: start accepted at edge T gives the first dout_valid at edge T+1+LATENCY, provided dout_ready was held at 1.
- Throughput: with dout_ready held at 1, one beat per cycle; a full sweep is exactly M beats.
- Backpressure: when dout_valid=1 and dout_ready=0, dout_a, dout_b, dout_samp and dout_last are held stable.
  - Upstream stages freeze, and issue stops once all stages hold data.
  - No beat is lost or duplicated.
  - After backpressure is released, consecutive beats resume with no bubble.
- Ordering: dout_samp runs 0,1,...,M-1 strictly in order. dout_last=1 only with dout_samp=M-1.
- ch_a == ch_b is legal; both outputs then carry identical data.
- Writes are accepted only when busy=0.
  - wr_en while busy=1: the write is dropped, memory is unchanged, and err pulses.
  - wr_samp>=M or wr_ch>=N: the write is dropped and err pulses.
- A write and an accepted start in the same cycle: the write commits, and the sweep reads the new value.
- err is a single pulse that ORs all rejection causes in the cycle.
- Reset mid-sweep: the sweep aborts immediately with no done. Outputs return to 0 and the state is IDLE. Memory is untouched.

Test Plan:
- Load Z[s][c]=s*8+c for M=16, N=7; start with ch_a=2, ch_b=5, dout_ready=1 -> beats 0..15 with dout_a=s*8+2 and dout_b=s*8+5; first valid at T+2 (LATENCY=1); dout_last only at s=15; done one cycle after.
- Same sweep with dout_ready toggling 1,0,0,1 repeatedly -> dout_a/dout_b/dout_samp stable during stalls; exactly 16 unique in-order beats.
- start with ch_a=7 (N=7) -> err=1 for one cycle, busy stays 0, no dout_valid. start during a sweep -> err, sweep unaffected.
- wr_en with wr_samp=3, wr_ch=1, data 0x7FFF while busy -> err; subsequent sweep of channel 1 returns the original value at s=3.
- Assert rst_n=0 at beat 5 of a sweep -> all outputs 0 asynchronously, no done; rerun the sweep after release -> data unchanged.
- LATENCY=4, ch_a=ch_b=0 -> first valid at T+5; both outputs equal; back-to-back start in the done cycle accepted.
